// File: rtl/haar_face_scan_if.sv
// haar_face_scan_if: tile word input stream and detected-box output stream
interface haar_face_scan_if #(parameter int DATA_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              box_valid;
    logic              box_ready;
    logic [15:0]       box_x;
    logic [15:0]       box_y;
    logic [15:0]       box_w;
    logic [15:0]       box_h;
    modport master (output in_valid, in_data, box_ready, input in_ready, box_valid, box_x, box_y, box_w, box_h);
    modport slave  (input in_valid, in_data, box_ready, output in_ready, box_valid, box_x, box_y, box_w, box_h);
endinterface

// File: rtl/haar_face_scan.sv
// haar_face_scan: loads one integral-image tile, scans an eye/nose/mouth Haar cascade over all scales, streams box records
module haar_face_scan #(
    parameter int SIDE       = 48,
    parameter int DATA_W     = 32,
    parameter int BASE_W     = 12,
    parameter int STEP_W     = 6,
    parameter int NUM_SCALES = 6,
    parameter int EYE_LO     = 110,
    parameter int EYE_HI     = 212,
    parameter int BRIGHT_TH  = 237,
    parameter int EYEP_TH    = 196,
    parameter int MOUTH_TH   = 206
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    haar_face_scan_if.slave bus
);
    localparam int N  = SIDE * SIDE;
    localparam int AW = $clog2(N);
    localparam int KW = NUM_SCALES > 1 ? $clog2(NUM_SCALES) : 1;
    localparam int SW = DATA_W + 2;
    localparam logic signed [SW-1:0] T_EYE_LO = SW'(EYE_LO);
    localparam logic signed [SW-1:0] T_EYE_HI = SW'(EYE_HI);
    localparam logic signed [SW-1:0] T_BRIGHT = SW'(BRIGHT_TH);
    localparam logic signed [SW-1:0] T_EYEP   = SW'(EYEP_TH);
    localparam logic signed [SW-1:0] T_MOUTH  = SW'(MOUTH_TH);

    typedef enum logic [3:0] {IDLE, LOAD, EYE, NOSE, MOUTH1, MOUTH2, EMIT, NEXT, DONE} state_t;

    state_t               state;
    logic [DATA_W-1:0]    mem [N];
    logic [AW-1:0]        addr, x, y;
    logic [KW-1:0]        k;
    logic [AW-1:0]        w_tab [NUM_SCALES];
    logic [AW-1:0]        h_tab [NUM_SCALES];
    logic [AW-1:0]        e_tab [NUM_SCALES];
    logic [AW-1:0]        w, h, e, x_l, x_r, x_w, y_1, y_2, y_3, y_4, y_m;
    logic signed [SW-1:0] a_wh, a_n, a_e, eye, cheek, nose, eye_1, eye_2, mouth;
    logic                 eye_ok, nose_ok, mouth_ok, last_x, last_y, last_k, xy_end;

    // per-scale geometry is constant, so h and e come from tables rather than dividers
    for (genvar g = 0; g < NUM_SCALES; g++) begin : g_scale
        localparam int W = BASE_W + g * STEP_W;
        assign w_tab[g] = AW'(W);
        assign h_tab[g] = AW'(W / 6);
        assign e_tab[g] = AW'(W / 5);
    end

    function automatic logic signed [SW-1:0] rect(input logic [AW-1:0] x0, y0, x1, y1);
        return $signed(SW'(mem[AW'(y1 * SIDE + x1)])) - $signed(SW'(mem[AW'(y1 * SIDE + x0)]))
             - $signed(SW'(mem[AW'(y0 * SIDE + x1)])) + $signed(SW'(mem[AW'(y0 * SIDE + x0)]));
    endfunction

    assign w   = w_tab[k];
    assign h   = h_tab[k];
    assign e   = e_tab[k];
    assign x_w = x + w;
    assign x_l = x + e + e;
    assign x_r = x_w - e - e;
    assign y_1 = y + h;
    assign y_2 = y_1 + h;
    assign y_3 = y_2 + h;
    assign y_4 = y_3 + h;
    assign y_m = state == MOUTH2 ? y_3 : y_2;

    assign a_wh  = SW'(w) * SW'(h);
    assign a_n   = SW'(h) * SW'(x_r - x_l);
    assign a_e   = SW'(h) * SW'(e + e);
    assign eye   = rect(x, y, x_w, y_1);
    assign cheek = rect(x, y_1, x_w, y_2);
    assign nose  = rect(x_l, y, x_r, y_1);
    assign eye_1 = rect(x_r, y, x_w, y_1);
    assign eye_2 = rect(x, y, x_l, y_1);
    assign mouth = rect(x_l, y_m, x_r, y_m + h);

    // mean tests are done as sum against threshold*area
    assign eye_ok   = eye > T_EYE_LO * a_wh && eye < T_EYE_HI * a_wh && cheek > T_BRIGHT * a_wh;
    assign nose_ok  = nose > T_BRIGHT * a_n && eye_1 < T_EYEP * a_e && eye_2 < T_EYEP * a_e;
    assign mouth_ok = mouth <= T_MOUTH * a_n;
    assign last_x   = x_w == AW'(SIDE - 1);
    assign last_y   = y_4 == AW'(SIDE - 1);
    assign last_k   = k == KW'(NUM_SCALES - 1);
    assign xy_end   = last_x && last_y;

    always_ff @(posedge clk)
        if (bus.in_valid && bus.in_ready) mem[addr] <= bus.in_data;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state         <= IDLE;
            addr          <= '0;
            x             <= '0;
            y             <= '0;
            k             <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.box_valid <= 1'b0;
            bus.box_x     <= '0;
            bus.box_y     <= '0;
            bus.box_w     <= '0;
            bus.box_h     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    state        <= LOAD;
                    bus.in_ready <= 1'b1;
                    busy         <= 1'b1;
                    addr         <= '0;
                    x            <= '0;
                    y            <= '0;
                    k            <= '0;
                end
                LOAD: if (bus.in_valid) begin
                    addr <= addr + 1'b1;
                    if (addr == AW'(N - 1)) begin
                        state        <= EYE;
                        bus.in_ready <= 1'b0;
                    end
                end
                EYE:  state <= eye_ok ? NOSE : NEXT;
                NOSE: state <= nose_ok ? MOUTH1 : NEXT;
                MOUTH1, MOUTH2: if (mouth_ok) begin
                    state         <= EMIT;
                    bus.box_valid <= 1'b1;
                    bus.box_x     <= 16'(x);
                    bus.box_y     <= 16'(y);
                    bus.box_w     <= 16'(w);
                    bus.box_h     <= 16'(h) << 2;
                end else state <= state == MOUTH1 ? MOUTH2 : NEXT;
                EMIT: if (bus.box_ready) begin
                    state         <= NEXT;
                    bus.box_valid <= 1'b0;
                end
                NEXT: begin
                    x     <= last_x ? '0 : x + 1'b1;
                    y     <= !last_x ? y : last_y ? '0 : y + 1'b1;
                    k     <= !xy_end ? k : last_k ? '0 : k + 1'b1;
                    state <= xy_end && last_k ? DONE : EYE;
                    busy  <= !(xy_end && last_k);
                    done  <= xy_end && last_k;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_haar_face_scan.sv
// tb_haar_face_scan: directed tiles checked against a pixel-level model of the face cascade
module tb_haar_face_scan;
    localparam int SIDE = 48;
    localparam int N    = SIDE * SIDE;

    typedef struct {int x; int y; int w; int h;} box_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic busy, done;

    haar_face_scan_if #(.DATA_W(32)) bus ();

    haar_face_scan dut (.clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus.slave));

    always #5 clk = ~clk;

    int          pix [SIDE][SIDE];
    int          ii  [SIDE][SIDE];
    logic [31:0] img [N];
    box_t        exp_q [$];
    int          checks = 0, errors = 0;
    int          done_cnt = 0, rx_cnt = 0, stall_cyc = 0, face_off = -1;
    bit          stall_arm = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int psum(input int x0, input int y0, input int x1, input int y1);
        int s = 0;
        for (int r = y0 + 1; r <= y1; r++)
            for (int c = x0 + 1; c <= x1; c++) s += pix[r][c];
        return s;
    endfunction

    function automatic real mean(input int x0, input int y0, input int x1, input int y1);
        return real'(psum(x0, y0, x1, y1)) / real'((x1 - x0) * (y1 - y0));
    endfunction

    function automatic int has_box(input int x, input int y, input int w, input int h);
        foreach (exp_q[i]) if (exp_q[i].x == x && exp_q[i].y == y && exp_q[i].w == w && exp_q[i].h == h) return 1;
        return 0;
    endfunction

    task automatic integrate();
        for (int r = 0; r < SIDE; r++)
            for (int c = 0; c < SIDE; c++) begin
                ii[r][c] = pix[r][c] + (r > 0 ? ii[r-1][c] : 0) + (c > 0 ? ii[r][c-1] : 0)
                         - (r > 0 && c > 0 ? ii[r-1][c-1] : 0);
                img[r * SIDE + c] = 32'(ii[r][c]);
            end
    endtask

    task automatic make_flat(input int v);
        for (int r = 0; r < SIDE; r++) for (int c = 0; c < SIDE; c++) pix[r][c] = v;
        integrate();
    endtask

    // face at (10,6), w=12: eye band rows 7-8, cheeks 9-10, mouth rows 11-12 or 13-14
    task automatic make_face(input bit low_mouth);
        for (int r = 0; r < SIDE; r++) for (int c = 0; c < SIDE; c++) pix[r][c] = 0;
        for (int c = 11; c <= 22; c++) begin
            pix[7][c]  = (c >= 15 && c <= 18) ? 250 : 100;
            pix[8][c]  = pix[7][c];
            pix[9][c]  = 250;
            pix[10][c] = 250;
        end
        for (int c = 15; c <= 18; c++) begin
            pix[11][c] = low_mouth ? 255 : 150;
            pix[12][c] = low_mouth ? 255 : 150;
            pix[13][c] = low_mouth ? 150 : 0;
            pix[14][c] = low_mouth ? 150 : 0;
        end
        integrate();
    endtask

    // expected boxes in scan order and the cycle offset of the (10,6) scale-0 window
    task automatic build_model();
        int cyc = 0;
        exp_q.delete();
        face_off = -1;
        for (int s = 0; s < 6; s++) begin
            int w = 12 + 6 * s;
            int h = w / 6;
            int e = w / 5;
            for (int y = 0; y <= SIDE - 1 - 4 * h; y++)
                for (int x = 0; x <= SIDE - 1 - w; x++) begin
                    bit ok_e, ok_n, ok_1, ok_2;
                    real m_eye;
                    m_eye = mean(x, y, x + w, y + h);
                    ok_e = m_eye > 110.0 && m_eye < 212.0 && mean(x, y + h, x + w, y + 2 * h) > 237.0;
                    ok_n = mean(x + 2 * e, y, x + w - 2 * e, y + h) > 237.0 && mean(x + w - 2 * e, y, x + w, y + h) < 196.0
                         && mean(x, y, x + 2 * e, y + h) < 196.0;
                    ok_1 = mean(x + 2 * e, y + 2 * h, x + w - 2 * e, y + 3 * h) <= 206.0;
                    ok_2 = mean(x + 2 * e, y + 3 * h, x + w - 2 * e, y + 4 * h) <= 206.0;
                    if (s == 0 && x == 10 && y == 6) face_off = cyc;
                    cyc += !ok_e ? 2 : !ok_n ? 3 : ok_1 ? 5 : ok_2 ? 6 : 5;
                    if (ok_e && ok_n && (ok_1 || ok_2)) exp_q.push_back('{x, y, w, 4 * h});
                end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load(input bit gap);
        int i = 0, t = 0;
        bit ph = 1'b1, hs;
        while (i < N && t < 4 * N) begin
            bus.in_valid = gap ? ph : 1'b1;
            bus.in_data  = img[i];
            ph = !ph;
            @(negedge clk);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (hs) i++;
            t++;
        end
        bus.in_valid = 1'b0;
        check("load_words", i, N);
    endtask

    task automatic run_scan(input bit gap, input bit poke);
        int n = 0;
        int want = exp_q.size();
        done_cnt = 0;
        rx_cnt   = 0;
        pulse_start();
        load(gap);
        if (poke) pulse_start();
        while (done_cnt == 0 && n < 30000) begin @(posedge clk); #1; n++; end
        repeat (4) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", int'(busy), 0);
        check("box_count", rx_cnt, want);
        check("box_leftover", exp_q.size(), 0);
    endtask

    // holds box_ready low for 20 cycles on the first box after arming
    initial begin
        bus.box_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_arm && bus.box_valid) begin
                bus.box_ready = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                bus.box_ready = 1'b1;
                stall_arm = 1'b0;
            end
        end
    end

    initial begin
        box_t b;
        bit held = 1'b0;
        int hx = 0, hy = 0, hw = 0, hh = 0;
        forever begin
            @(negedge clk);
            if (!reset) held = 1'b0;
            else begin
                if (done) done_cnt++;
                if (bus.box_valid || bus.in_ready) check("valid_ready_excl", int'(bus.box_valid && bus.in_ready), 0);
                if (bus.box_valid) begin
                    if (held) begin
                        check("hold_x", int'(bus.box_x), hx);
                        check("hold_y", int'(bus.box_y), hy);
                        check("hold_w", int'(bus.box_w), hw);
                        check("hold_h", int'(bus.box_h), hh);
                    end
                    if (bus.box_ready) begin
                        held = 1'b0;
                        if (exp_q.size() == 0) check("unexpected_box_x", int'(bus.box_x), -1);
                        else begin
                            b = exp_q.pop_front();
                            check("box_x", int'(bus.box_x), b.x);
                            check("box_y", int'(bus.box_y), b.y);
                            check("box_w", int'(bus.box_w), b.w);
                            check("box_h", int'(bus.box_h), b.h);
                            rx_cnt++;
                        end
                    end else begin
                        held = 1'b1;
                        stall_cyc++;
                        hx = int'(bus.box_x); hy = int'(bus.box_y); hw = int'(bus.box_w); hh = int'(bus.box_h);
                    end
                end else held = 1'b0;
            end
        end
    end

    initial begin
        int want2;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_box_valid", int'(bus.box_valid), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // flat bright tile, plus a start pulse mid-scan that must be ignored
        make_flat(255);
        build_model();
        check("pin_flat_empty", exp_q.size(), 0);
        run_scan(1'b0, 1'b1);

        // face with upper mouth band, first box back-pressured for 20 cycles
        make_face(1'b0);
        check("pin_eye_sum", psum(10, 6, 22, 8), 3600);
        check("pin_cheek_sum", psum(10, 8, 22, 10), 6000);
        build_model();
        check("pin_face_box", has_box(10, 6, 12, 8), 1);
        want2 = exp_q.size();
        stall_cyc = 0;
        stall_arm = 1'b1;
        run_scan(1'b0, 1'b0);
        check("stall_cycles", stall_cyc, 20);

        // face with only the lower mouth band
        make_face(1'b1);
        build_model();
        check("pin_mouth2_box", has_box(10, 6, 12, 8), 1);
        run_scan(1'b0, 1'b0);

        // same face as before, loaded with in_valid toggling
        make_face(1'b0);
        build_model();
        run_scan(1'b1, 1'b0);
        check("gap_box_count", rx_cnt, want2);

        // reset while the face window is in its nose stage, then a flat tile
        make_face(1'b0);
        build_model();
        check("face_off_found", int'(face_off >= 0), 1);
        pulse_start();
        load(1'b0);
        repeat (face_off + 1) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_in_ready", int'(bus.in_ready), 0);
        check("abort_box_valid", int'(bus.box_valid), 0);
        check("abort_box_x", int'(bus.box_x), 0);
        check("abort_box_y", int'(bus.box_y), 0);
        check("abort_box_w", int'(bus.box_w), 0);
        check("abort_box_h", int'(bus.box_h), 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        make_flat(255);
        build_model();
        run_scan(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
